// File: rtl/click_select_ctrl_pkg.sv
// Shared types and constants for the two-click source/destination move selector.
package click_select_ctrl_pkg;

  localparam int unsigned NUM_COLS       = 18;
  localparam int unsigned NUM_ROWS       = 8;
  localparam int unsigned HAND_ROW_FIRST = 6;
  localparam int unsigned BLK_X_W        = 5;
  localparam int unsigned BLK_Y_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRC  = 2'd1,
    ST_REQ  = 2'd2
  } state_e;

  // Block coordinate payload carried between selection and move registers
  typedef struct packed {
    logic [BLK_X_W-1:0] x;
    logic [BLK_Y_W-1:0] y;
  } blk_t;

endpackage

// File: rtl/click_select_ctrl_sel_timeout_cnt.sv
// Saturating cycle counter; done_c is high once the count reaches MAX_COUNT-1.
module sel_timeout_cnt #(
  parameter int unsigned MAX_COUNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign done_c = (cnt_q == LAST);

endmodule

// File: rtl/click_select_ctrl.sv
// Turns click pulses into a pick-source / pick-destination move request with
// selection timeout and a one-cycle cheat request passthrough.
module click_select_ctrl
  import click_select_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned NUM_COLS       = click_select_ctrl_pkg::NUM_COLS,
  parameter int unsigned NUM_ROWS       = click_select_ctrl_pkg::NUM_ROWS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         my_turn,
  input  logic         l_click,
  input  logic         mouse_inblock,
  input  logic [4:0]   mouse_block_x,
  input  logic [2:0]   mouse_block_y,
  input  logic         cheat_activate,
  input  logic         move_ack,
  output logic         sel_valid,
  output logic [4:0]   sel_x,
  output logic [2:0]   sel_y,
  output logic         move_req,
  output logic [4:0]   move_src_x,
  output logic [2:0]   move_src_y,
  output logic [4:0]   move_dst_x,
  output logic [2:0]   move_dst_y,
  output logic         cheat_req
);

  state_e state_q, state_nxt;
  blk_t   sel_q, sel_nxt;
  blk_t   src_q, src_nxt;
  blk_t   dst_q, dst_nxt;
  blk_t   cursor_c;
  logic   sel_valid_q, move_req_q, cheat_q;
  logic   click_ok_c, cnt_clr_c, timeout_c;

  assign cursor_c   = '{x: mouse_block_x, y: mouse_block_y};
  assign click_ok_c = l_click && mouse_inblock && my_turn
                      && ({27'd0, mouse_block_x} < NUM_COLS)
                      && ({29'd0, mouse_block_y} < NUM_ROWS);

  sel_timeout_cnt #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_c),
    .en     (state_q == ST_SRC),
    .done_c (timeout_c)
  );

  // Next-state and next-payload decode; a click outranks the timeout
  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    cnt_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (click_ok_c) begin
          sel_nxt   = cursor_c;
          cnt_clr_c = 1'b1;
          state_nxt = ST_SRC;
        end
      end
      ST_SRC: begin
        if (click_ok_c) begin
          if (cursor_c == sel_q) begin
            state_nxt = ST_IDLE;
          end else begin
            src_nxt   = sel_q;
            dst_nxt   = cursor_c;
            state_nxt = ST_REQ;
          end
        end else if (l_click && !mouse_inblock) begin
          state_nxt = ST_IDLE;
        end else if (!my_turn) begin
          state_nxt = ST_IDLE;
        end else if (timeout_c) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (move_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      sel_valid_q <= 1'b0;
      move_req_q  <= 1'b0;
      cheat_q     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      sel_q       <= sel_nxt;
      src_q       <= src_nxt;
      dst_q       <= dst_nxt;
      sel_valid_q <= (state_nxt == ST_SRC);
      move_req_q  <= (state_nxt == ST_REQ);
      cheat_q     <= cheat_activate && (state_q != ST_REQ);
    end
  end

  assign sel_valid  = sel_valid_q;
  assign sel_x      = sel_q.x;
  assign sel_y      = sel_q.y;
  assign move_req   = move_req_q;
  assign move_src_x = src_q.x;
  assign move_src_y = src_q.y;
  assign move_dst_x = dst_q.x;
  assign move_dst_y = dst_q.y;
  assign cheat_req  = cheat_q;

endmodule

// File: tb/tb_click_select_ctrl.sv
// Directed self-checking bench for click_select_ctrl with a 16-cycle timeout.
module tb_click_select_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       my_turn;
  logic       l_click;
  logic       mouse_inblock;
  logic [4:0] mouse_block_x;
  logic [2:0] mouse_block_y;
  logic       cheat_activate;
  logic       move_ack;
  logic       sel_valid;
  logic [4:0] sel_x;
  logic [2:0] sel_y;
  logic       move_req;
  logic [4:0] move_src_x;
  logic [2:0] move_src_y;
  logic [4:0] move_dst_x;
  logic [2:0] move_dst_y;
  logic       cheat_req;

  int checks = 0;
  int fails  = 0;

  click_select_ctrl #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .my_turn        (my_turn),
    .l_click        (l_click),
    .mouse_inblock  (mouse_inblock),
    .mouse_block_x  (mouse_block_x),
    .mouse_block_y  (mouse_block_y),
    .cheat_activate (cheat_activate),
    .move_ack       (move_ack),
    .sel_valid      (sel_valid),
    .sel_x          (sel_x),
    .sel_y          (sel_y),
    .move_req       (move_req),
    .move_src_x     (move_src_x),
    .move_src_y     (move_src_y),
    .move_dst_x     (move_dst_x),
    .move_dst_y     (move_dst_y),
    .cheat_req      (cheat_req)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic click(input logic [4:0] x, input logic [2:0] y, input logic inb);
    l_click       = 1'b1;
    mouse_inblock = inb;
    mouse_block_x = x;
    mouse_block_y = y;
    step();
    l_click       = 1'b0;
    mouse_inblock = 1'b0;
  endtask

  task automatic ack();
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; my_turn = 1'b0; l_click = 1'b0; mouse_inblock = 1'b0;
    mouse_block_x = '0; mouse_block_y = '0; cheat_activate = 1'b0; move_ack = 1'b0;
    step(); step();
    checks++;
    if ({sel_valid, sel_x, sel_y, move_req, move_src_x, move_src_y, move_dst_x, move_dst_y, cheat_req} !== 27'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", {sel_valid, sel_x, sel_y, move_req, move_src_x, move_src_y, move_dst_x, move_dst_y, cheat_req});
    end
    rst = 1'b0;
    ack();
    checks++;
    if ({sel_valid, move_req} !== 2'b00) begin
      fails++; $display("FAIL ack_in_idle: got %b want 00", {sel_valid, move_req});
    end
    my_turn = 1'b1;
  endtask

  task automatic test_basic_move();
    click(5'd3, 3'd2, 1'b1);
    checks++;
    if ({sel_valid, sel_x, sel_y, move_req} !== {1'b1, 5'd3, 3'd2, 1'b0}) begin
      fails++; $display("FAIL basic_select: got v=%b (%0d,%0d) req=%b want v=1 (3,2) req=0", sel_valid, sel_x, sel_y, move_req);
    end
    click(5'd7, 3'd6, 1'b1);
    checks++;
    if ({sel_valid, move_req, move_src_x, move_src_y, move_dst_x, move_dst_y} !== {1'b0, 1'b1, 5'd3, 3'd2, 5'd7, 3'd6}) begin
      fails++; $display("FAIL basic_req: got v=%b req=%b src=(%0d,%0d) dst=(%0d,%0d) want v=0 req=1 src=(3,2) dst=(7,6)", sel_valid, move_req, move_src_x, move_src_y, move_dst_x, move_dst_y);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({move_req, move_src_x, move_src_y, move_dst_x, move_dst_y} !== {1'b1, 5'd3, 3'd2, 5'd7, 3'd6}) begin
        fails++; $display("FAIL basic_hold_%0d: got req=%b src=(%0d,%0d) dst=(%0d,%0d)", i, move_req, move_src_x, move_src_y, move_dst_x, move_dst_y);
      end
    end
    ack();
    checks++;
    if ({sel_valid, move_req} !== 2'b00) begin
      fails++; $display("FAIL basic_ack: got v=%b req=%b want 0 0", sel_valid, move_req);
    end
  endtask

  task automatic test_back_to_back();
    click(5'd5, 3'd0, 1'b1);
    click(5'd6, 3'd0, 1'b1);
    ack();
    checks++;
    if (move_req !== 1'b0) begin
      fails++; $display("FAIL min_req_ack: got req=%b want 0", move_req);
    end
    click(5'd2, 3'd1, 1'b1);
    checks++;
    if ({sel_valid, sel_x, sel_y} !== {1'b1, 5'd2, 3'd1}) begin
      fails++; $display("FAIL b2b_select: got v=%b (%0d,%0d) want v=1 (2,1)", sel_valid, sel_x, sel_y);
    end
    click(5'd2, 3'd1, 1'b1);
  endtask

  task automatic test_cancel();
    click(5'd4, 3'd1, 1'b1);
    checks++;
    if (sel_valid !== 1'b1) begin
      fails++; $display("FAIL same_first: got v=%b want 1", sel_valid);
    end
    click(5'd4, 3'd1, 1'b1);
    checks++;
    if ({sel_valid, move_req} !== 2'b00) begin
      fails++; $display("FAIL same_cancel: got v=%b req=%b want 0 0", sel_valid, move_req);
    end
    click(5'd4, 3'd1, 1'b1);
    click(5'd9, 3'd7, 1'b0);
    checks++;
    if ({sel_valid, move_req} !== 2'b00) begin
      fails++; $display("FAIL outside_cancel: got v=%b req=%b want 0 0", sel_valid, move_req);
    end
    my_turn = 1'b0;
    click(5'd4, 3'd1, 1'b1);
    checks++;
    if (sel_valid !== 1'b0) begin
      fails++; $display("FAIL not_my_turn: got v=%b want 0", sel_valid);
    end
    my_turn = 1'b1;
    click(5'd18, 3'd0, 1'b1);
    checks++;
    if (sel_valid !== 1'b0) begin
      fails++; $display("FAIL col_out_of_range: got v=%b want 0", sel_valid);
    end
    click(5'd17, 3'd7, 1'b1);
    checks++;
    if ({sel_valid, sel_x, sel_y} !== {1'b1, 5'd17, 3'd7}) begin
      fails++; $display("FAIL col_last: got v=%b (%0d,%0d) want v=1 (17,7)", sel_valid, sel_x, sel_y);
    end
    my_turn = 1'b0;
    step();
    checks++;
    if (sel_valid !== 1'b0) begin
      fails++; $display("FAIL turn_drop: got v=%b want 0", sel_valid);
    end
    my_turn = 1'b1;
  endtask

  task automatic test_timeout();
    click(5'd0, 3'd0, 1'b1);
    repeat (15) step();
    checks++;
    if (sel_valid !== 1'b1) begin
      fails++; $display("FAIL timeout_early: got v=%b want 1 at cycle 15", sel_valid);
    end
    step();
    checks++;
    if (sel_valid !== 1'b0) begin
      fails++; $display("FAIL timeout_fire: got v=%b want 0 at cycle 16", sel_valid);
    end
    click(5'd0, 3'd0, 1'b1);
    repeat (15) step();
    click(5'd1, 3'd0, 1'b1);
    checks++;
    if ({move_req, move_src_x, move_src_y, move_dst_x, move_dst_y} !== {1'b1, 5'd0, 3'd0, 5'd1, 3'd0}) begin
      fails++; $display("FAIL timeout_click_prio: got req=%b src=(%0d,%0d) dst=(%0d,%0d) want req=1 src=(0,0) dst=(1,0)", move_req, move_src_x, move_src_y, move_dst_x, move_dst_y);
    end
    ack();
  endtask

  task automatic test_req_ignores();
    click(5'd1, 3'd1, 1'b1);
    click(5'd2, 3'd2, 1'b1);
    click(5'd9, 3'd3, 1'b1);
    my_turn = 1'b0;
    step();
    checks++;
    if ({move_req, sel_valid, move_src_x, move_src_y, move_dst_x, move_dst_y} !== {1'b1, 1'b0, 5'd1, 3'd1, 5'd2, 3'd2}) begin
      fails++; $display("FAIL req_ignore_click: got req=%b v=%b src=(%0d,%0d) dst=(%0d,%0d) want req=1 v=0 src=(1,1) dst=(2,2)", move_req, sel_valid, move_src_x, move_src_y, move_dst_x, move_dst_y);
    end
    cheat_activate = 1'b1;
    step();
    cheat_activate = 1'b0;
    checks++;
    if (cheat_req !== 1'b0) begin
      fails++; $display("FAIL cheat_in_req: got %b want 0", cheat_req);
    end
    my_turn = 1'b1;
    ack();
    cheat_activate = 1'b1;
    step();
    cheat_activate = 1'b0;
    checks++;
    if (cheat_req !== 1'b1) begin
      fails++; $display("FAIL cheat_idle: got %b want 1", cheat_req);
    end
    step();
    checks++;
    if (cheat_req !== 1'b0) begin
      fails++; $display("FAIL cheat_one_cycle: got %b want 0", cheat_req);
    end
    cheat_activate = 1'b1;
    click(5'd5, 3'd5, 1'b1);
    cheat_activate = 1'b0;
    checks++;
    if ({cheat_req, sel_valid, sel_x, sel_y} !== {1'b1, 1'b1, 5'd5, 3'd5}) begin
      fails++; $display("FAIL cheat_with_click: got cheat=%b v=%b (%0d,%0d) want 1 1 (5,5)", cheat_req, sel_valid, sel_x, sel_y);
    end
    click(5'd5, 3'd5, 1'b1);
  endtask

  task automatic test_reset_in_req();
    click(5'd10, 3'd4, 1'b1);
    click(5'd11, 3'd5, 1'b1);
    checks++;
    if (move_req !== 1'b1) begin
      fails++; $display("FAIL rst_setup: got req=%b want 1", move_req);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({sel_valid, sel_x, sel_y, move_req, move_src_x, move_src_y, move_dst_x, move_dst_y, cheat_req} !== 27'd0) begin
      fails++; $display("FAIL rst_in_req: got %h want 0", {sel_valid, sel_x, sel_y, move_req, move_src_x, move_src_y, move_dst_x, move_dst_y, cheat_req});
    end
    ack();
    checks++;
    if ({sel_valid, move_req} !== 2'b00) begin
      fails++; $display("FAIL ack_after_rst: got v=%b req=%b want 0 0", sel_valid, move_req);
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_back_to_back();
    test_cancel();
    test_timeout();
    test_req_ignores();
    test_reset_in_req();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
